// File: rtl/top_pkg.sv
// Shared definitions for the vector-add demo: operating modes, default sizes
// and the seven-segment font.
package top_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;
  localparam logic [1:0] MODE_INC  = 2'b11;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 4;

  // Active-low cathodes ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/top_seven_seg_mux.sv
// Four-digit multiplexed seven-segment driver: free-running scan counter,
// one-hot-low anode select and hex decode of the selected nibble.
module seven_seg_mux
  import top_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        btnc,
  input  logic [15:0] digits,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;

  always_ff @(posedge clk) begin
    if (btnc) scan_cnt <= '0;
    else      scan_cnt <= scan_cnt + 1'b1;
  end

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    an    = 4'b1110;
    digit = digits[3:0];
    case (sel)
      2'd0: begin an = 4'b1110; digit = digits[3:0];   end
      2'd1: begin an = 4'b1101; digit = digits[7:4];   end
      2'd2: begin an = 4'b1011; digit = digits[11:8];  end
      default: begin an = 4'b0111; digit = digits[15:12]; end
    endcase
  end

  assign seg = hex_to_seg(digit);

endmodule

// File: rtl/top.sv
// Vector-add demo: two 1024-entry nibble vectors addressed from the switches,
// with add / write / single-shot increment modes and a 4-digit display.
module top
  import top_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        btnc,
  input  logic [15:0] sw,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] A_INIT_OFS = DATA_W'(3);
  localparam logic [DATA_W-1:0] B_INIT_OFS = DATA_W'(1);
  localparam logic [DATA_W-1:0] ONE        = DATA_W'(1);

  logic [1:0]        mode;
  logic [1:0]        prev_mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  assign mode  = sw[15:14];
  assign addr  = sw[4 +: ADDR_W];
  assign wdata = sw[DATA_W-1:0];

  // A is never written, so its power-up pattern (i+3) is generated from the
  // address. B is held as an offset from its power-up pattern (i+1); a
  // zero-initialised offset array gives the required contents at power-up.
  logic [DATA_W-1:0] b_ofs [0:DEPTH-1] = '{default: '0};
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_base;
  logic [DATA_W-1:0] b_rd;
  logic              inc_fire;

  assign a_rd     = addr[DATA_W-1:0] + A_INIT_OFS;
  assign b_base   = addr[DATA_W-1:0] + B_INIT_OFS;
  assign b_rd     = b_base + b_ofs[addr];
  assign inc_fire = (mode == MODE_INC) && (prev_mode != MODE_INC);

  always_ff @(posedge clk) begin
    if (!btnc) begin
      if (mode == MODE_WR)
        b_ofs[addr] <= wdata - b_base;
      else if (inc_fire)
        b_ofs[addr] <= b_ofs[addr] + ONE;
    end
  end

  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [DATA_W:0]   c_out;

  always_ff @(posedge clk) begin
    if (btnc) begin
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      prev_mode <= MODE_IDLE;
    end else begin
      prev_mode <= mode;
      if (mode == MODE_ADD) begin
        a_out <= a_rd;
        b_out <= b_rd;
        c_out <= {1'b0, a_rd} + {1'b0, b_rd};
      end
    end
  end

  logic [15:0] digits;
  assign digits = {a_out, b_out, 3'b000, c_out[DATA_W], c_out[DATA_W-1:0]};

  seven_seg_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_disp (
    .clk   (clk),
    .btnc  (btnc),
    .digits(digits),
    .seg   (seg),
    .an    (an)
  );

endmodule

// File: tb/tb_top.sv
// Directed bench for the vector-add demo: memory modes, reset priority and
// display scan order with a short refresh counter.
module tb_top;

  logic        clk = 1'b0;
  logic        btnc;
  logic [15:0] sw;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;

  top #(.REFRESH_BITS(4)) dut (
    .clk (clk),
    .btnc(btnc),
    .sw  (sw),
    .seg (seg),
    .an  (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_sw(input logic [1:0] mode, input logic [9:0] addr, input logic [3:0] data);
    sw = {mode, addr, data};
  endtask

  task automatic check_out(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [4:0] c);
    check({tag, "_a"}, 32'(dut.a_out), 32'(a));
    check({tag, "_b"}, 32'(dut.b_out), 32'(b));
    check({tag, "_c"}, 32'(dut.c_out), 32'(c));
  endtask

  // Expected digit drive for A=3, B=6, C=09 in scan order 0..3.
  logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'b0010000, 7'b1000000, 7'b0000010, 7'b0110000};

  initial begin
    btnc = 1'b1;
    sw   = 16'h0000;
    step(2);
    check_out("reset", 4'h0, 4'h0, 5'h00);
    check("reset_an", 32'(an), 32'(4'b1110));
    check("reset_seg", 32'(seg), 32'(7'b1000000));
    btnc = 1'b0;

    // Add at address 0: A=3, B=1.
    set_sw(2'b01, 10'd0, 4'h0);
    step(1);
    check_out("add0_lat1", 4'h3, 4'h1, 5'h04);
    step(9);
    check_out("add0", 4'h3, 4'h1, 5'h04);

    // Write B[0]=5; outputs hold while writing.
    set_sw(2'b10, 10'd0, 4'h5);
    step(2);
    check_out("wr0_hold", 4'h3, 4'h1, 5'h04);
    set_sw(2'b01, 10'd0, 4'h0);
    step(1);
    check_out("wr0_add", 4'h3, 4'h5, 5'h08);

    // Increment held for two cycles bumps B[0] only once.
    set_sw(2'b11, 10'd0, 4'h0);
    step(2);
    check_out("inc0_hold", 4'h3, 4'h5, 5'h08);
    set_sw(2'b01, 10'd0, 4'h0);
    step(1);
    check_out("inc0_add", 4'h3, 4'h6, 5'h09);

    // Increment wrap: B[7]=F -> 0, A[7]=A.
    set_sw(2'b10, 10'd7, 4'hF);
    step(1);
    set_sw(2'b11, 10'd7, 4'h0);
    step(3);
    set_sw(2'b01, 10'd7, 4'h0);
    step(1);
    check_out("incwrap", 4'hA, 4'h0, 5'h0A);

    // Max sum: A[12]=F, B[12]=F.
    set_sw(2'b10, 10'd12, 4'hF);
    step(1);
    set_sw(2'b01, 10'd12, 4'h0);
    step(1);
    check_out("maxsum", 4'hF, 4'hF, 5'h1E);

    // Address change while held in increment does not re-trigger.
    set_sw(2'b11, 10'd20, 4'h0);
    step(1);
    set_sw(2'b11, 10'd21, 4'h0);
    step(2);
    set_sw(2'b01, 10'd20, 4'h0);
    step(1);
    check_out("inc20", 4'h7, 4'h6, 5'h0D);
    set_sw(2'b01, 10'd21, 4'h0);
    step(1);
    check_out("inc21_untouched", 4'h8, 4'h6, 5'h0E);

    // Reset wins over a write to B[1].
    set_sw(2'b10, 10'd1, 4'h9);
    btnc = 1'b1;
    step(1);
    check_out("rst_wr", 4'h0, 4'h0, 5'h00);
    btnc = 1'b0;
    set_sw(2'b01, 10'd1, 4'h0);
    step(1);
    check_out("rst_wr_blocked", 4'h4, 4'h2, 5'h06);
    set_sw(2'b10, 10'd1, 4'h9);
    step(1);
    set_sw(2'b01, 10'd1, 4'h0);
    step(1);
    check_out("wr_resume", 4'h4, 4'h9, 5'h0D);

    // Display scan: reset aligns the counter, then add at address 0.
    set_sw(2'b01, 10'd0, 4'h0);
    btnc = 1'b1;
    step(1);
    check("scan_rst_an", 32'(an), 32'(4'b1110));
    btnc = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      int s;
      step(1);
      s = (k % 16) / 4;
      check($sformatf("scan_an_k%0d", k), 32'(an), 32'(exp_an[s]));
      check($sformatf("scan_seg_k%0d", k), 32'(seg), 32'(exp_seg[s]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
